// File: rtl/rv32e_mem_arbiter.sv
// rv32e_mem_arbiter
//   Shares one single-port unified memory between the CPU instruction-fetch
//   port (imem_*) and data port (dmem_*). Data requests win over fetches,
//   except that after MAX_D_BURST consecutive data grants with a fetch
//   waiting, the fetch is forced through. An access that sees no mem_ack for
//   TIMEOUT_CYCLES cycles is aborted and reported on bus_error.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   imem_*            fetch request (level, held until imem_ready) / data out
//   dmem_*            load/store request (level, held until dmem_ready)
//   mem_*             memory side: req held until ack or abort, word address
//   bus_error         one-cycle pulse alongside the ready of an aborted access
//   grant_is_data     1 when the current/last grant went to the data port
module rv32e_mem_arbiter #(
    parameter int unsigned MAX_D_BURST    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] imem_addr,
    input  logic        imem_read,
    output logic [31:0] imem_data,
    output logic        imem_ready,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_data_out,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [3:0]  dmem_byte_enable,
    output logic [31:0] dmem_data_in,
    output logic        dmem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_error,
    output logic        grant_is_data
);

    localparam int unsigned BW = (MAX_D_BURST > 0) ? $clog2(MAX_D_BURST + 1) : 1;
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_D_BURST);
    localparam logic [15:0]   TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] burst_cnt;
    logic [15:0]   tcnt;
    logic          dreq;
    logic          fetch_forced;
    logic          grant_d;
    logic          grant_i;
    logic          timeout;

    // Byte offset bits never reach the memory: accesses are word aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{imem_addr[1:0], dmem_addr[1:0]};

    assign dreq         = dmem_read | dmem_write;
    assign fetch_forced = imem_read && (burst_cnt == BURST_MAX);
    assign grant_d      = dreq && !fetch_forced;
    assign grant_i      = imem_read && !grant_d;
    assign timeout      = (tcnt == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_d || grant_i) state_nxt = BUSY;
            BUSY:    if (mem_ack || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_be        <= '0;
            imem_data     <= '0;
            dmem_data_in  <= '0;
            imem_ready    <= 1'b0;
            dmem_ready    <= 1'b0;
            bus_error     <= 1'b0;
            grant_is_data <= 1'b0;
            burst_cnt     <= '0;
            tcnt          <= '0;
        end else begin
            // Completion pulses are raised on BUSY->DONE and last one cycle.
            imem_ready <= 1'b0;
            dmem_ready <= 1'b0;
            bus_error  <= 1'b0;
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (grant_d) begin
                        mem_req       <= 1'b1;
                        mem_we        <= dmem_write;
                        mem_addr      <= {dmem_addr[31:2], 2'b00};
                        mem_wdata     <= dmem_write ? dmem_data_out : '0;
                        mem_be        <= dmem_write ? dmem_byte_enable : '1;
                        grant_is_data <= 1'b1;
                    end else if (grant_i) begin
                        mem_req       <= 1'b1;
                        mem_we        <= 1'b0;
                        mem_addr      <= {imem_addr[31:2], 2'b00};
                        mem_wdata     <= '0;
                        mem_be        <= '1;
                        grant_is_data <= 1'b0;
                    end
                    // Counts data grants that overtook a waiting fetch.
                    if (!imem_read || grant_i) begin
                        burst_cnt <= '0;
                    end else if (grant_d && (burst_cnt != BURST_MAX)) begin
                        burst_cnt <= burst_cnt + BW'(1);
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            if (grant_is_data) dmem_data_in <= mem_rdata;
                            else               imem_data    <= mem_rdata;
                        end
                        dmem_ready <= grant_is_data;
                        imem_ready <= !grant_is_data;
                    end else if (timeout) begin
                        mem_req   <= 1'b0;
                        bus_error <= 1'b1;
                        if (grant_is_data) dmem_data_in <= '0;
                        else               imem_data    <= '0;
                        dmem_ready <= grant_is_data;
                        imem_ready <= !grant_is_data;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
